piso_serializer: RTL

- Upstream stage feeding the 4-bit serial-in/parallel-out shift register: accepts parallel words through a valid/ready handshake and drives them out one bit per clock on a single serial line.
- A 2-entry input FIFO decouples the producer from the shift engine, so back-to-back words stream with no idle gap.
- Bit order is LSB-first: after WIDTH shifts, the downstream register's parallel output equals the original word ({q3,q2,q1,q0} = word).

---
 rtl/piso_serializer.sv | 71 +++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: 2-entry FIFO feeding an LSB-first parallel-to-serial shift engine.
// Back-to-back words stream with no idle gap between the last and first bits.
module piso_serializer #(
   parameter int   WIDTH      = 4,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             word_done,
   output logic             busy,
   output logic [1:0]       fifo_count
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_d;
   logic [WIDTH-1:0] mem [2];
   logic [WIDTH-1:0] sh, sh_d;
   logic [CW-1:0] cnt, cnt_d;
   logic wp, rp, push, pop, last, sout_d, valid_d, done_d;

   assign in_ready = ~fifo_count[1];
   assign push     = in_valid & in_ready;
   assign last     = cnt == CW'(WIDTH-1);
   assign pop      = (fifo_count != 2'd0) && (state == IDLE || last);
   assign busy     = state == SHIFT;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_d;

   always_comb
      state_d = (pop || (state == SHIFT && !last)) ? SHIFT : IDLE;

   // Next-cycle output values; a load presents bit 0 immediately.
   always_comb begin
      sh_d    = pop ? mem[rp] : sh >> 1;
      cnt_d   = pop ? '0 : cnt + CW'(1);
      sout_d  = pop ? mem[rp][0] : (state_d == SHIFT) ? sh[1] : IDLE_LEVEL;
      valid_d = state_d == SHIFT;
      done_d  = (state_d == SHIFT) && (cnt_d == CW'(WIDTH-1));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sh         <= '0;
         cnt        <= '0;
         sout       <= IDLE_LEVEL;
         sout_valid <= 1'b0;
         word_done  <= 1'b0;
         wp         <= 1'b0;
         rp         <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         sh         <= sh_d;
         cnt        <= cnt_d;
         sout       <= sout_d;
         sout_valid <= valid_d;
         word_done  <= done_d;
         wp         <= wp ^ push;
         rp         <= rp ^ pop;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      end

   always_ff @(posedge clk)
      if (push) mem[wp] <= in_data;
endmodule
